video_timing_gen: RTL and testbench

VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

---
 rtl/video_timing_gen.sv | 105 ++++++++++
 tb/tb_video_timing_gen.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// Raster timing generator: free-running h/v counters expose the scan position to object
// blocks and mix their pixel into a registered RGB/sync/de stream with one-cycle latency.
module video_timing_gen #(
    parameter int          HRES     = 1280,
    parameter int          HFP      = 110,
    parameter int          HSW      = 40,
    parameter int          HBP      = 220,
    parameter int          VRES     = 720,
    parameter int          VFP      = 5,
    parameter int          VSW      = 5,
    parameter int          VBP      = 20,
    parameter bit          SYNC_POL = 1'b1,
    parameter logic [23:0] BG_COLOR = 24'h000000
) (
    input  logic               pixel_clk,
    input  logic               rst,
    output logic signed [11:0] hpos,
    output logic signed [11:0] vpos,
    output logic               fsync,
    input  logic [7:0]         obj_pixel [0:2],
    input  logic               obj_active,
    output logic [23:0]        rgb,
    output logic               hsync,
    output logic               vsync,
    output logic               de
);

    localparam int HTOT = HRES + HFP + HSW + HBP;
    localparam int VTOT = VRES + VFP + VSW + VBP;

    localparam logic [10:0] H_ACT  = 11'(HRES);
    localparam logic [10:0] H_SS   = 11'(HRES + HFP);
    localparam logic [10:0] H_SE   = 11'(HRES + HFP + HSW - 1);
    localparam logic [10:0] H_LAST = 11'(HTOT - 1);
    localparam logic [10:0] V_ACT  = 11'(VRES);
    localparam logic [10:0] V_SS   = 11'(VRES + VFP);
    localparam logic [10:0] V_SE   = 11'(VRES + VFP + VSW - 1);
    localparam logic [10:0] V_LAST = 11'(VTOT - 1);

    logic [10:0] hcnt;
    logic [10:0] vcnt;
    logic [10:0] hnext;
    logic [10:0] vnext;
    logic        active_p0;
    logic        hsync_p0;
    logic        vsync_p0;
    logic        vld_p1;
    logic        hsync_p1;
    logic        vsync_p1;
    logic [23:0] rgb_p1;

    function automatic logic [23:0] pick_pixel(input logic in_active, input logic obj_on,
                                               input logic [7:0] r, input logic [7:0] g,
                                               input logic [7:0] b);
        if (!in_active)
            return 24'h000000;
        if (obj_on)
            return {r, g, b};
        return BG_COLOR;
    endfunction

    always_comb begin
        hnext = hcnt + 11'd1;
        vnext = vcnt;
        if (hcnt == H_LAST) begin
            hnext = '0;
            vnext = (vcnt == V_LAST) ? '0 : vcnt + 11'd1;
        end
    end

    // Stage p0: decode the current scan position; object inputs are sampled alongside.
    assign active_p0 = (hcnt < H_ACT) && (vcnt < V_ACT);
    assign hsync_p0  = (hcnt >= H_SS) && (hcnt <= H_SE);
    assign vsync_p0  = (vcnt >= V_SS) && (vcnt <= V_SE);

    // fsync is precomputed from the next counts so it lines up with hpos=0, vpos=VRES.
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            hcnt     <= '0;
            vcnt     <= '0;
            fsync    <= 1'b0;
            vld_p1   <= 1'b0;
            rgb_p1   <= 24'h000000;
            hsync_p1 <= ~SYNC_POL;
            vsync_p1 <= ~SYNC_POL;
        end else begin
            hcnt     <= hnext;
            vcnt     <= vnext;
            fsync    <= (hnext == '0) && (vnext == V_ACT);
            vld_p1   <= active_p0;
            rgb_p1   <= pick_pixel(active_p0, obj_active, obj_pixel[2], obj_pixel[1], obj_pixel[0]);
            hsync_p1 <= hsync_p0 ? SYNC_POL : ~SYNC_POL;
            vsync_p1 <= vsync_p0 ? SYNC_POL : ~SYNC_POL;
        end
    end

    // Stage p1: registered stream to the encoder, one cycle behind hpos/vpos.
    assign hpos  = $signed({1'b0, hcnt});
    assign vpos  = $signed({1'b0, vcnt});
    assign de    = vld_p1;
    assign rgb   = rgb_p1;
    assign hsync = hsync_p1;
    assign vsync = vsync_p1;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen on a reduced 28x17 raster (476 cycles per frame).
module tb_video_timing_gen;

    localparam logic [23:0] BG = 24'h123456;

    logic               pixel_clk;
    logic               rst;
    logic signed [11:0] hpos;
    logic signed [11:0] vpos;
    logic               fsync;
    logic [7:0]         obj_pixel [0:2];
    logic               obj_active;
    logic [23:0]        rgb;
    logic               hsync;
    logic               vsync;
    logic               de;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          h;
        int          v;
        logic        act;
        logic [23:0] pix;
        logic [23:0] rgb;
        logic        de;
        logic        hs;
        logic        vs;
    } vec_t;

    vec_t vecs [15];

    video_timing_gen #(
        .HRES(16), .HFP(4), .HSW(3), .HBP(5),
        .VRES(10), .VFP(2), .VSW(2), .VBP(3),
        .SYNC_POL(1'b1), .BG_COLOR(BG)
    ) dut (
        .pixel_clk (pixel_clk),
        .rst       (rst),
        .hpos      (hpos),
        .vpos      (vpos),
        .fsync     (fsync),
        .obj_pixel (obj_pixel),
        .obj_active(obj_active),
        .rgb       (rgb),
        .hsync     (hsync),
        .vsync     (vsync),
        .de        (de)
    );

    initial pixel_clk = 1'b0;
    always #5 pixel_clk = ~pixel_clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic set_obj(input logic act, input logic [23:0] p);
        obj_active   = act;
        obj_pixel[2] = p[23:16];
        obj_pixel[1] = p[15:8];
        obj_pixel[0] = p[7:0];
    endtask

    // Returns at a falling edge where the DUT shows (h, v); checks the current cycle first.
    task automatic wait_pos(input int h, input int v, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (int'(hpos) == h && int'(vpos) == v) begin
                ok = 1'b1;
                break;
            end
            @(negedge pixel_clk);
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL wait_pos: position (%0d,%0d) never reached", h, v);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_hpos"}, 32'(hpos), 0);
        chk({tag, "_vpos"}, 32'(vpos), 0);
        chk({tag, "_fsync"}, 32'(fsync), 0);
        chk({tag, "_de"}, 32'(de), 0);
        chk({tag, "_rgb"}, 32'(rgb), 0);
        chk({tag, "_hsync"}, 32'(hsync), 0);
        chk({tag, "_vsync"}, 32'(vsync), 0);
    endtask

    initial begin
        bit ok;
        int cyc, npulse, de_n, hs_n, vs_n, leak, k;
        int t [3];

        vecs[0]  = '{0,  0,  1'b0, 24'h000000, BG,         1'b1, 1'b0, 1'b0};
        vecs[1]  = '{4,  3,  1'b0, 24'h000000, BG,         1'b1, 1'b0, 1'b0};
        vecs[2]  = '{5,  3,  1'b1, 24'h00FF90, 24'h00FF90, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{6,  3,  1'b0, 24'h000000, BG,         1'b1, 1'b0, 1'b0};
        vecs[4]  = '{16, 3,  1'b1, 24'hAABBCC, 24'h000000, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{19, 4,  1'b0, 24'h000000, 24'h000000, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{20, 4,  1'b1, 24'hFFFFFF, 24'h000000, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{22, 4,  1'b0, 24'h000000, 24'h000000, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{23, 4,  1'b0, 24'h000000, 24'h000000, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{15, 9,  1'b1, 24'hAABBCC, 24'hAABBCC, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{0,  10, 1'b1, 24'hAABBCC, 24'h000000, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{27, 11, 1'b0, 24'h000000, 24'h000000, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{0,  12, 1'b0, 24'h000000, 24'h000000, 1'b0, 1'b0, 1'b1};
        vecs[13] = '{21, 13, 1'b1, 24'hFFFFFF, 24'h000000, 1'b0, 1'b1, 1'b1};
        vecs[14] = '{0,  14, 1'b0, 24'h000000, 24'h000000, 1'b0, 1'b0, 1'b0};

        rst = 1'b1;
        set_obj(1'b0, 24'h000000);
        repeat (3) @(negedge pixel_clk);
        chk_reset_state("reset");

        rst = 1'b0;
        chk("release_hpos0", 32'(hpos), 0);
        @(negedge pixel_clk);
        chk("release_hpos1", 32'(hpos), 1);
        chk("release_vpos", 32'(vpos), 0);

        // Three frames' worth of fsync timing with the object forced on everywhere.
        set_obj(1'b1, 24'hFFFFFF);
        cyc = 0; npulse = 0; de_n = 0; hs_n = 0; vs_n = 0; leak = 0;
        t[0] = 0; t[1] = 0; t[2] = 0;
        while (npulse < 3 && cyc < 2000) begin
            @(negedge pixel_clk);
            cyc++;
            if (fsync) begin
                if (npulse < 3) t[npulse] = cyc;
                npulse++;
                chk("fsync_hpos", 32'(hpos), 0);
                chk("fsync_vpos", 32'(vpos), 10);
            end
            if (npulse == 1) begin
                de_n += int'(de);
                hs_n += int'(hsync);
                vs_n += int'(vsync);
            end
            if (rgb !== (de ? 24'hFFFFFF : 24'h000000)) leak++;
        end
        chk("fsync_count", 32'(npulse), 3);
        chk("fsync_first", 32'(t[0]), 279);
        chk("fsync_period1", 32'(t[1] - t[0]), 476);
        chk("fsync_period2", 32'(t[2] - t[1]), 476);
        chk("frame_de_cycles", 32'(de_n), 160);
        chk("frame_hsync_cycles", 32'(hs_n), 51);
        chk("frame_vsync_cycles", 32'(vs_n), 56);
        chk("blank_rgb_leak", 32'(leak), 0);
        set_obj(1'b0, 24'h000000);

        for (int i = 0; i < 15; i++) begin
            wait_pos(vecs[i].h, vecs[i].v, ok);
            if (!ok) continue;
            set_obj(vecs[i].act, vecs[i].pix);
            @(negedge pixel_clk);
            chk($sformatf("vec%0d_rgb", i), 32'(rgb), 32'(vecs[i].rgb));
            chk($sformatf("vec%0d_de", i), 32'(de), 32'(vecs[i].de));
            chk($sformatf("vec%0d_hsync", i), 32'(hsync), 32'(vecs[i].hs));
            chk($sformatf("vec%0d_vsync", i), 32'(vsync), 32'(vecs[i].vs));
            set_obj(1'b0, 24'h000000);
        end

        // Reset mid-frame while both syncs are asserted.
        wait_pos(21, 12, ok);
        if (ok) begin
            @(negedge pixel_clk);
            chk("pre_reset_hsync", 32'(hsync), 1);
            chk("pre_reset_vsync", 32'(vsync), 1);
            rst = 1'b1;
            @(negedge pixel_clk);
            chk_reset_state("midreset");
            rst = 1'b0;
            k = 0;
            while (k < 1000) begin
                @(negedge pixel_clk);
                k++;
                if (fsync) break;
            end
            chk("midreset_fsync_delay", 32'(k), 280);
            chk("midreset_fsync_hpos", 32'(hpos), 0);
            chk("midreset_fsync_vpos", 32'(vpos), 10);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
